// File: rtl/branch_predictor_btb_if.sv
// Fetch/execute-side signal bundle between the datapath and the BTB branch predictor.
// The datapath is the master: it supplies PCs, pipeline controls and resolved outcomes.
interface branch_predictor_btb_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] PCF;
    logic [XLEN-1:0] PCPlus4F;
    logic            StallF;
    logic            StallD;
    logic            FlushD;
    logic            FlushE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic            BranchE;
    logic            JumpE;
    logic            JalrE;
    logic            ActualTakenE;
    logic [XLEN-1:0] ActualTargetE;
    logic [XLEN-1:0] PredNextPCF;
    logic            PredTakenF;
    logic            MispredictE;
    logic [XLEN-1:0] RedirectPCE;

    modport master (
        output PCF, PCPlus4F, StallF, StallD, FlushD, FlushE,
               PCE, PCPlus4E, BranchE, JumpE, JalrE, ActualTakenE, ActualTargetE,
        input  PredNextPCF, PredTakenF, MispredictE, RedirectPCE
    );

    modport slave (
        input  PCF, PCPlus4F, StallF, StallD, FlushD, FlushE,
               PCE, PCPlus4E, BranchE, JumpE, JalrE, ActualTakenE, ActualTargetE,
        output PredNextPCF, PredTakenF, MispredictE, RedirectPCE
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters: zero-latency fetch lookup, F->D->E shadow
// pipeline for the prediction, and E-stage resolution/training.
module branch_predictor_btb #(
    parameter int INDEX_BITS = 4,
    parameter int XLEN       = 32
) (
    input logic                clk,
    input logic                rst,
    branch_predictor_btb_if.slave bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = XLEN - INDEX_BITS - 2;

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
    } predT;

    logic [ENTRIES-1:0] validQ;
    logic [TAG_W-1:0]   tagQ    [ENTRIES];
    logic [XLEN-1:0]    targetQ [ENTRIES];
    logic [1:0]         ctrQ    [ENTRIES];

    logic [INDEX_BITS-1:0] idxF, idxE;
    logic [TAG_W-1:0]      tagF, tagE;
    logic                  hitF, hitE, ctrlE, predTakenF;
    logic                  wrongDir, wrongTarget;
    predT                  predD, predE;
    logic                  unusedBits;

    // StallF and the byte-offset bits carry no information for the predictor.
    assign unusedBits = ^{bp.StallF, bp.PCF[1:0], bp.PCE[1:0]};

    assign idxF = bp.PCF[INDEX_BITS+1:2];
    assign tagF = bp.PCF[XLEN-1:INDEX_BITS+2];
    assign idxE = bp.PCE[INDEX_BITS+1:2];
    assign tagE = bp.PCE[XLEN-1:INDEX_BITS+2];

    assign hitF           = validQ[idxF] && (tagQ[idxF] == tagF);
    assign hitE           = validQ[idxE] && (tagQ[idxE] == tagE);
    assign predTakenF     = hitF && ctrQ[idxF][1];
    assign bp.PredTakenF  = predTakenF;
    assign bp.PredNextPCF = predTakenF ? targetQ[idxF] : bp.PCPlus4F;

    always_ff @(posedge clk) begin
        if (rst) begin
            predD <= '0;
            predE <= '0;
        end else begin
            if (bp.FlushD)       predD <= '0;
            else if (!bp.StallD) predD <= {predTakenF, bp.PredNextPCF};
            if (bp.FlushE)       predE <= '0;
            else                 predE <= predD;
        end
    end

    assign ctrlE       = bp.BranchE | bp.JumpE | bp.JalrE;
    assign wrongDir    = predE.taken != bp.ActualTakenE;
    assign wrongTarget = predE.taken & bp.ActualTakenE & (predE.target != bp.ActualTargetE);
    // A predicted-taken non-control instruction means an aliased entry steered fetch wrongly.
    assign bp.MispredictE = ctrlE ? (wrongDir | wrongTarget) : predE.taken;
    assign bp.RedirectPCE = (ctrlE & bp.ActualTakenE) ? bp.ActualTargetE : bp.PCPlus4E;

    always_ff @(posedge clk) begin
        if (rst) begin
            validQ <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tagQ[i]    <= '0;
                targetQ[i] <= '0;
                ctrQ[i]    <= 2'b01;
            end
        end else if (ctrlE && hitE) begin
            if (bp.ActualTakenE) begin
                if (ctrQ[idxE] != 2'b11) ctrQ[idxE] <= ctrQ[idxE] + 2'd1;
                targetQ[idxE] <= bp.ActualTargetE;
            end else if (ctrQ[idxE] != 2'b00) begin
                ctrQ[idxE] <= ctrQ[idxE] - 2'd1;
            end
        end else if (ctrlE && bp.ActualTakenE) begin
            validQ[idxE]  <= 1'b1;
            tagQ[idxE]    <= tagE;
            targetQ[idxE] <= bp.ActualTargetE;
            ctrQ[idxE]    <= 2'b10;
        end else if (!ctrlE && predE.taken) begin
            validQ[idxE] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed scenarios plus randomized traffic against
// a table-level reference model of the BTB and its prediction pipeline.
module tb_branch_predictor_btb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_btb_if #(.XLEN(32)) bp ();
    branch_predictor_btb #(.INDEX_BITS(4), .XLEN(32)) dut (.clk(clk), .rst(rst), .bp(bp));

    int nCmp = 0;
    int nErr = 0;

    // Reference model: one record per BTB slot, counter kept as a plain integer 0..3.
    bit          mValid [16];
    logic [25:0] mTag   [16];
    logic [31:0] mTgt   [16];
    int          mCnt   [16];
    bit          dTk, eTk;
    logic [31:0] dTgt, eTgt;

    function automatic void predictF(input logic [31:0] pc, output bit tk, output logic [31:0] nxt);
        int idx;
        bit hit;
        idx = int'(pc[5:2]);
        hit = mValid[idx] && (mTag[idx] == pc[31:6]);
        tk  = hit && (mCnt[idx] >= 2);
        nxt = tk ? mTgt[idx] : pc + 32'd4;
    endfunction

    function automatic bit expMisp();
        bit ctrl;
        ctrl = bp.BranchE || bp.JumpE || bp.JalrE;
        if (!ctrl) return eTk;
        if (eTk != bp.ActualTakenE) return 1'b1;
        return eTk && bp.ActualTakenE && (eTgt != bp.ActualTargetE);
    endfunction

    function automatic logic [31:0] expRedir();
        bit ctrl;
        ctrl = bp.BranchE || bp.JumpE || bp.JalrE;
        return (ctrl && bp.ActualTakenE) ? bp.ActualTargetE : bp.PCE + 32'd4;
    endfunction

    task automatic setF(input logic [31:0] pc);
        bp.PCF      = pc;
        bp.PCPlus4F = pc + 32'd4;
    endtask

    task automatic setE(input logic [31:0] pc, input bit br, input bit j, input bit jr,
                        input bit tk, input logic [31:0] tgt);
        bp.PCE           = pc;
        bp.PCPlus4E      = pc + 32'd4;
        bp.BranchE       = br;
        bp.JumpE         = j;
        bp.JalrE         = jr;
        bp.ActualTakenE  = tk;
        bp.ActualTargetE = tgt;
    endtask

    task automatic idleE();
        setE(32'h2008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Advance one clock; the model applies the same edge's effects from the driven inputs.
    task automatic tick();
        bit          fTk, ctrl, act, hit;
        logic [31:0] fNxt;
        int          idx;
        predictF(bp.PCF, fTk, fNxt);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mValid[i] = 1'b0; mTag[i] = '0; mTgt[i] = '0; mCnt[i] = 1;
            end
            dTk = 1'b0; dTgt = '0; eTk = 1'b0; eTgt = '0;
        end else begin
            ctrl = bp.BranchE || bp.JumpE || bp.JalrE;
            act  = bp.ActualTakenE;
            idx  = int'(bp.PCE[5:2]);
            hit  = mValid[idx] && (mTag[idx] == bp.PCE[31:6]);
            if (ctrl && hit) begin
                if (act) begin
                    if (mCnt[idx] < 3) mCnt[idx]++;
                    mTgt[idx] = bp.ActualTargetE;
                end else if (mCnt[idx] > 0) begin
                    mCnt[idx]--;
                end
            end else if (ctrl && act) begin
                mValid[idx] = 1'b1; mTag[idx] = bp.PCE[31:6]; mTgt[idx] = bp.ActualTargetE; mCnt[idx] = 2;
            end else if (!ctrl && eTk) begin
                mValid[idx] = 1'b0;
            end
            if (bp.FlushE) begin eTk = 1'b0; eTgt = '0; end
            else begin eTk = dTk; eTgt = dTgt; end
            if (bp.FlushD) begin dTk = 1'b0; dTgt = '0; end
            else if (!bp.StallD) begin dTk = fTk; dTgt = fNxt; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        setF(32'h40); idleE(); #1;
        nCmp++; if (bp.PredTakenF !== 1'b0) begin nErr++; $display("FAIL reset_predtaken: got %0b want 0", bp.PredTakenF); end
        nCmp++; if (bp.PredNextPCF !== 32'h44) begin nErr++; $display("FAIL reset_nextpc: got %h want 00000044", bp.PredNextPCF); end
        for (int i = 0; i < 3; i++) begin
            nCmp++; if (bp.MispredictE !== 1'b0) begin nErr++; $display("FAIL reset_bubble_misp%0d: got %0b want 0", i, bp.MispredictE); end
            tick(); #1;
        end
    endtask

    task automatic test_cold_taken();
        setF(32'h2008); setE(32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80); #1;
        nCmp++; if (bp.MispredictE !== 1'b1) begin nErr++; $display("FAIL cold_misp: got %0b want 1", bp.MispredictE); end
        nCmp++; if (bp.RedirectPCE !== 32'h80) begin nErr++; $display("FAIL cold_redirect: got %h want 00000080", bp.RedirectPCE); end
        tick();
        idleE(); setF(32'h40); #1;
        nCmp++; if (bp.PredTakenF !== 1'b1) begin nErr++; $display("FAIL cold_predtaken: got %0b want 1", bp.PredTakenF); end
        nCmp++; if (bp.PredNextPCF !== 32'h80) begin nErr++; $display("FAIL cold_nextpc: got %h want 00000080", bp.PredNextPCF); end
        tick();
    endtask

    task automatic test_not_taken();
        setF(32'h2008); tick();
        setE(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80); #1;
        nCmp++; if (bp.MispredictE !== 1'b1) begin nErr++; $display("FAIL nt_first_misp: got %0b want 1", bp.MispredictE); end
        nCmp++; if (bp.RedirectPCE !== 32'h44) begin nErr++; $display("FAIL nt_first_redirect: got %h want 00000044", bp.RedirectPCE); end
        tick(); #1;
        nCmp++; if (bp.MispredictE !== 1'b0) begin nErr++; $display("FAIL nt_second_misp: got %0b want 0", bp.MispredictE); end
        tick();
        idleE(); setF(32'h40); #1;
        nCmp++; if (bp.PredTakenF !== 1'b0) begin nErr++; $display("FAIL nt_predtaken: got %0b want 0", bp.PredTakenF); end
        nCmp++; if (bp.PredNextPCF !== 32'h44) begin nErr++; $display("FAIL nt_nextpc: got %h want 00000044", bp.PredNextPCF); end
        tick();
    endtask

    task automatic test_alias();
        setF(32'h2008); setE(32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80);
        tick(); tick();
        idleE(); setF(32'h440); #1;
        nCmp++; if (bp.PredTakenF !== 1'b0) begin nErr++; $display("FAIL alias_predtaken: got %0b want 0", bp.PredTakenF); end
        nCmp++; if (bp.PredNextPCF !== 32'h444) begin nErr++; $display("FAIL alias_nextpc: got %h want 00000444", bp.PredNextPCF); end
        tick();
        setF(32'h40); #1;
        nCmp++; if (bp.PredTakenF !== 1'b1) begin nErr++; $display("FAIL alias_retrained: got %0b want 1", bp.PredTakenF); end
        tick();
        setF(32'h2008); tick();
        setE(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
        nCmp++; if (bp.MispredictE !== 1'b1) begin nErr++; $display("FAIL alias_misp: got %0b want 1", bp.MispredictE); end
        nCmp++; if (bp.RedirectPCE !== 32'h44) begin nErr++; $display("FAIL alias_redirect: got %h want 00000044", bp.RedirectPCE); end
        tick();
        idleE(); setF(32'h40); #1;
        nCmp++; if (bp.PredTakenF !== 1'b0) begin nErr++; $display("FAIL alias_invalidated: got %0b want 0", bp.PredTakenF); end
        tick();
    endtask

    task automatic test_jalr();
        setF(32'h2008); setE(32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
        tick();
        idleE(); setF(32'h100); #1;
        nCmp++; if (bp.PredNextPCF !== 32'h200) begin nErr++; $display("FAIL jalr_alloc_nextpc: got %h want 00000200", bp.PredNextPCF); end
        tick();
        setF(32'h2008); tick();
        setE(32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300); #1;
        nCmp++; if (bp.MispredictE !== 1'b1) begin nErr++; $display("FAIL jalr_misp: got %0b want 1", bp.MispredictE); end
        nCmp++; if (bp.RedirectPCE !== 32'h300) begin nErr++; $display("FAIL jalr_redirect: got %h want 00000300", bp.RedirectPCE); end
        tick();
        idleE(); setF(32'h100); #1;
        nCmp++; if (bp.PredTakenF !== 1'b1) begin nErr++; $display("FAIL jalr_predtaken: got %0b want 1", bp.PredTakenF); end
        nCmp++; if (bp.PredNextPCF !== 32'h300) begin nErr++; $display("FAIL jalr_new_target: got %h want 00000300", bp.PredNextPCF); end
    endtask

    task automatic test_stall_flush();
        tick();
        bp.StallD = 1'b1; setF(32'h2008); tick();
        #1;
        nCmp++; if (bp.MispredictE !== 1'b1) begin nErr++; $display("FAIL stall_e_taken: got %0b want 1", bp.MispredictE); end
        nCmp++; if (bp.RedirectPCE !== 32'h200C) begin nErr++; $display("FAIL stall_redirect: got %h want 0000200c", bp.RedirectPCE); end
        tick();
        bp.StallD = 1'b0; bp.FlushE = 1'b1; #1;
        nCmp++; if (bp.MispredictE !== 1'b1) begin nErr++; $display("FAIL stall_held_d: got %0b want 1", bp.MispredictE); end
        tick();
        bp.FlushE = 1'b0; #1;
        nCmp++; if (bp.MispredictE !== 1'b0) begin nErr++; $display("FAIL flush_e_bubble: got %0b want 0", bp.MispredictE); end
        setF(32'h100); #1;
        nCmp++; if (bp.PredNextPCF !== 32'h300) begin nErr++; $display("FAIL flush_no_train: got %h want 00000300", bp.PredNextPCF); end
        tick();
    endtask

    task automatic test_random();
        bit          tk;
        logic [31:0] nxt, pc, tgt;
        int          cls;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            pc  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
            setF(pc);
            cls = $urandom_range(0, 3);
            pc  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
            tgt = 32'($urandom_range(1, 63)) << 2;
            tk  = (cls == 1) ? bit'($urandom_range(0, 1)) : (cls >= 2);
            setE(pc, cls == 1, cls == 2, cls == 3, tk, tgt);
            bp.StallD = ($urandom_range(0, 7) == 0);
            bp.FlushD = ($urandom_range(0, 9) == 0);
            bp.FlushE = ($urandom_range(0, 9) == 0);
            bp.StallF = bit'($urandom_range(0, 1));
            #1;
            predictF(bp.PCF, tk, nxt);
            nCmp++; if (bp.PredTakenF !== tk) begin nErr++; $display("FAIL rnd%0d_predtaken: got %0b want %0b", n, bp.PredTakenF, tk); end
            nCmp++; if (bp.PredNextPCF !== nxt) begin nErr++; $display("FAIL rnd%0d_nextpc: got %h want %h", n, bp.PredNextPCF, nxt); end
            nCmp++; if (bp.MispredictE !== expMisp()) begin nErr++; $display("FAIL rnd%0d_misp: got %0b want %0b", n, bp.MispredictE, expMisp()); end
            nCmp++; if (bp.RedirectPCE !== expRedir()) begin nErr++; $display("FAIL rnd%0d_redirect: got %h want %h", n, bp.RedirectPCE, expRedir()); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        setF(32'h0); idleE();
        bp.StallF = 1'b0; bp.StallD = 1'b0; bp.FlushD = 1'b0; bp.FlushE = 1'b0;
        @(negedge clk);
        test_reset();
        test_cold_taken();
        test_not_taken();
        test_alias();
        test_jalr();
        test_stall_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
